// File: rtl/gbc_cpu_bus_bridge_if.sv
// Wishbone (pipelined, 8-bit data / 16-bit address) link between the CPU bus
// bridge and the system memory bus.
//   master : bridge side, drives CYC/STB/WE/SEL/ADDR/DAT_ToTarget
//   slave  : target side, drives DAT_ToInitiator/ACK/STALL
interface gbc_cpu_bus_bridge_if;
  logic        CYC;
  logic        STB;
  logic        WE;
  logic        SEL;
  logic [15:0] ADDR;
  logic [7:0]  DAT_ToTarget;
  logic [7:0]  DAT_ToInitiator;
  logic        ACK;
  logic        STALL;

  modport master (
    output CYC, STB, WE, SEL, ADDR, DAT_ToTarget,
    input  DAT_ToInitiator, ACK, STALL
  );

  modport slave (
    input  CYC, STB, WE, SEL, ADDR, DAT_ToTarget,
    output DAT_ToInitiator, ACK, STALL
  );
endinterface

// File: rtl/gbc_cpu_bus_bridge.sv
// SM83 CPU -> Wishbone bridge. Turns the CPU's strobe-style access (qualified
// by the CATC clock enable) into one pipelined Wishbone transaction per strobe
// and stalls the CPU through Delay until the transaction finishes or times out.
//   CLK, RST_N         : clock, async active-low reset
//   Ce                 : CPU clock enable; CPU-side inputs sampled only when high
//   Read/Write         : CPU strobes (both high = write)
//   Address/DataOut    : CPU address / write data
//   DataIn             : read data to CPU, held until the next completed read
//   Delay              : stall request to CATC
//   BusError           : one-cycle pulse on timeout abort
//   wb                 : Wishbone master port
module gbc_cpu_bus_bridge #(
  parameter int         TimeoutCycles = 255,
  parameter logic [7:0] ErrorData     = 8'hFF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Ce,
  input  logic        Read,
  input  logic        Write,
  input  logic [15:0] Address,
  input  logic [7:0]  DataOut,
  output logic [7:0]  DataIn,
  output logic        Delay,
  output logic        BusError,
  gbc_cpu_bus_bridge_if.master wb
);

  localparam int CW = $clog2(TimeoutCycles + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          state;
  logic            prev_strobe;
  logic [CW-1:0]   cnt;
  logic            strobe;
  logic            launch;
  logic            timeout_hit;

  assign strobe      = Read | Write;
  // Edge-detect on the strobe so a strobe held over several Ce cycles
  // produces a single transaction.
  assign launch      = Ce & strobe & ~prev_strobe & (state == IDLE);
  // Counter reaches TimeoutCycles on this edge.
  assign timeout_hit = (cnt == CW'(TimeoutCycles - 1));

  // Gated by RST_N so the stall request drops with the async reset even
  // while the CPU still presents a strobe.
  assign Delay = RST_N & (launch | (state == REQ) | (state == WAIT));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state           <= IDLE;
      prev_strobe     <= 1'b0;
      cnt             <= '0;
      DataIn          <= 8'hFF;
      BusError        <= 1'b0;
      wb.CYC          <= 1'b0;
      wb.STB          <= 1'b0;
      wb.SEL          <= 1'b0;
      wb.WE           <= 1'b0;
      wb.ADDR         <= '0;
      wb.DAT_ToTarget <= '0;
    end else begin
      BusError <= 1'b0;
      if (Ce) prev_strobe <= strobe;

      case (state)
        IDLE: begin
          if (launch) begin
            wb.ADDR         <= Address;
            wb.DAT_ToTarget <= DataOut;
            wb.WE           <= Write;
            wb.CYC          <= 1'b1;
            wb.STB          <= 1'b1;
            wb.SEL          <= 1'b1;
            cnt             <= '0;
            state           <= REQ;
          end
        end

        REQ: begin
          cnt <= cnt + 1'b1;
          // ACK only counts once the strobe is accepted (STALL low);
          // an ACK under STALL is a target protocol error and is ignored.
          if (!wb.STALL && wb.ACK) begin
            wb.CYC <= 1'b0;
            wb.STB <= 1'b0;
            wb.SEL <= 1'b0;
            if (!wb.WE) DataIn <= wb.DAT_ToInitiator;
            state  <= DONE;
          end else if (timeout_hit) begin
            wb.CYC   <= 1'b0;
            wb.STB   <= 1'b0;
            wb.SEL   <= 1'b0;
            if (!wb.WE) DataIn <= ErrorData;
            BusError <= 1'b1;
            state    <= DONE;
          end else if (!wb.STALL) begin
            wb.STB <= 1'b0;
            wb.SEL <= 1'b0;
            state  <= WAIT;
          end
        end

        WAIT: begin
          cnt <= cnt + 1'b1;
          if (wb.ACK) begin
            wb.CYC <= 1'b0;
            if (!wb.WE) DataIn <= wb.DAT_ToInitiator;
            state  <= DONE;
          end else if (timeout_hit) begin
            wb.CYC   <= 1'b0;
            if (!wb.WE) DataIn <= ErrorData;
            BusError <= 1'b1;
            state    <= DONE;
          end
        end

        // One idle beat so Delay releases with DataIn already valid.
        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gbc_cpu_bus_bridge.sv
// Directed bench for gbc_cpu_bus_bridge (TimeoutCycles = 8). Each launch
// pushes the expected transaction into a queue; it is popped when the strobe
// appears on the bus and its read data compared when the bridge completes.
module tb_gbc_cpu_bus_bridge;

  logic        clk;
  logic        rst_n;
  logic        Ce;
  logic        Read;
  logic        Write;
  logic [15:0] Address;
  logic [7:0]  DataOut;
  logic [7:0]  DataIn;
  logic        Delay;
  logic        BusError;

  gbc_cpu_bus_bridge_if bus();

  gbc_cpu_bus_bridge #(.TimeoutCycles(8), .ErrorData(8'hFF)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .Ce       (Ce),
    .Read     (Read),
    .Write    (Write),
    .Address  (Address),
    .DataOut  (DataOut),
    .DataIn   (DataIn),
    .Delay    (Delay),
    .BusError (BusError),
    .wb       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdat;
    logic [7:0]  rdat;   // DataIn expected once the transaction completes
  } txn_t;

  txn_t sb[$];
  txn_t cur;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] exp_datain;

  // Counts CYC assertions, sampled away from the active edge.
  int   cyc_rise = 0;
  logic prev_cyc = 1'b0;
  always @(negedge clk) begin
    prev_cyc <= bus.CYC;
    if (bus.CYC && !prev_cyc) cyc_rise <= cyc_rise + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic we, input logic [7:0] wd, input logic [7:0] rd);
    txn_t t;
    t.addr = a; t.we = we; t.wdat = wd; t.rdat = rd;
    sb.push_back(t);
  endtask

  // Nominal read: launch (cycle 0), STB (1), ACK (2), DONE (3).
  task automatic do_read(input logic [15:0] a, input logic [7:0] rd);
    Ce = 1'b1; Read = 1'b1; Write = 1'b0; Address = a;
    #1 chk("rd_launch_delay", Delay, 1'b1);
    exp_datain = rd;
    push(a, 1'b0, 8'h00, rd);
    @(negedge clk);
    cur = sb.pop_front();
    chk("rd_stb", {bus.CYC, bus.STB, bus.SEL}, 3'b111);
    chk("rd_addr", bus.ADDR, cur.addr);
    chk("rd_we", bus.WE, cur.we);
    chk("rd_delay1", Delay, 1'b1);
    @(negedge clk);
    chk("rd_wait", {bus.CYC, bus.STB}, 2'b10);
    chk("rd_delay2", Delay, 1'b1);
    bus.ACK = 1'b1; bus.DAT_ToInitiator = rd;
    @(negedge clk);
    bus.ACK = 1'b0; bus.DAT_ToInitiator = 8'h00;
    chk("rd_done_cyc", bus.CYC, 1'b0);
    chk("rd_datain", DataIn, cur.rdat);
    chk("rd_done_delay", Delay, 1'b0);
    chk("rd_berr", BusError, 1'b0);
    Read = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; Ce = 1'b0; Read = 1'b0; Write = 1'b0;
    Address = '0; DataOut = '0;
    bus.ACK = 1'b0; bus.STALL = 1'b0; bus.DAT_ToInitiator = '0;
    exp_datain = 8'hFF;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_bus", {bus.CYC, bus.STB, bus.WE, bus.SEL}, 4'b0000);
    chk("rst_addr", bus.ADDR, 16'h0000);
    chk("rst_dat", bus.DAT_ToTarget, 8'h00);
    chk("rst_datain", DataIn, 8'hFF);
    chk("rst_delay_berr", {Delay, BusError}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal read 0xC000 -> 0x5A
    do_read(16'hC000, 8'h5A);
    chk("t1_cyc_count", cyc_rise, 1);

    // Write 0x8123 <- 0x3C, STALL for 4 cycles, stray ACK under STALL
    Ce = 1'b1; Write = 1'b1; Address = 16'h8123; DataOut = 8'h3C; bus.STALL = 1'b1;
    #1 chk("wr_launch_delay", Delay, 1'b1);
    push(16'h8123, 1'b1, 8'h3C, exp_datain);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) cur = sb.pop_front();
      chk("wr_stb", {bus.CYC, bus.STB, bus.SEL}, 3'b111);
      chk("wr_fields", {bus.ADDR, bus.WE, bus.DAT_ToTarget}, {cur.addr, cur.we, cur.wdat});
      chk("wr_delay", Delay, 1'b1);
      bus.ACK = (i == 2);
      if (i == 5) bus.STALL = 1'b0;
    end
    @(negedge clk);
    chk("wr_wait", {bus.CYC, bus.STB, Delay}, 3'b101);
    bus.ACK = 1'b1;
    @(negedge clk);
    bus.ACK = 1'b0;
    chk("wr_done", {bus.CYC, Delay, BusError}, 3'b000);
    chk("wr_datain", DataIn, cur.rdat);
    chk("wr_hold", {bus.ADDR, bus.WE, bus.DAT_ToTarget}, {16'h8123, 1'b1, 8'h3C});
    Write = 1'b0;
    @(negedge clk);

    // Read strobe held across 3 Ce pulses -> one transaction
    begin
      int base;
      base = cyc_rise;
      Ce = 1'b1; Read = 1'b1; Address = 16'h0100;
      #1 chk("hold_launch", Delay, 1'b1);
      exp_datain = 8'h77;
      push(16'h0100, 1'b0, 8'h00, 8'h77);
      @(negedge clk);
      cur = sb.pop_front();
      chk("hold_req", {bus.CYC, bus.ADDR}, {1'b1, cur.addr});
      Ce = 1'b0;
      @(negedge clk);
      chk("hold_ce_low_delay", Delay, 1'b1);
      bus.ACK = 1'b1; bus.DAT_ToInitiator = 8'h77; Ce = 1'b1;
      @(negedge clk);
      bus.ACK = 1'b0; Ce = 1'b0;
      chk("hold_datain", DataIn, cur.rdat);
      @(negedge clk);
      Ce = 1'b1;
      #1 chk("hold_no_relaunch", Delay, 1'b0);
      @(negedge clk);
      #1 chk("hold_one_cyc", cyc_rise, base + 1);
      chk("hold_idle", bus.CYC, 1'b0);
      Read = 1'b0;
      @(negedge clk);
      do_read(16'h0100, 8'h88);
      chk("hold_second_cyc", cyc_rise, base + 2);
    end

    // Timeout read: no ACK, TimeoutCycles = 8
    Ce = 1'b1; Read = 1'b1; Address = 16'h4000;
    #1 chk("to_launch", Delay, 1'b1);
    exp_datain = 8'hFF;
    push(16'h4000, 1'b0, 8'h00, 8'hFF);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) cur = sb.pop_front();
      chk("to_cyc_high", {bus.CYC, Delay, BusError}, 3'b110);
    end
    @(negedge clk);
    chk("to_abort", {bus.CYC, bus.STB, bus.SEL}, 3'b000);
    chk("to_berr", BusError, 1'b1);
    chk("to_datain", DataIn, cur.rdat);
    chk("to_delay", Delay, 1'b0);
    Read = 1'b0;
    @(negedge clk);
    chk("to_berr_pulse", BusError, 1'b0);

    // Read+Write together is a write
    Ce = 1'b1; Read = 1'b1; Write = 1'b1; Address = 16'h2222; DataOut = 8'h11;
    push(16'h2222, 1'b1, 8'h11, exp_datain);
    @(negedge clk);
    cur = sb.pop_front();
    chk("rw_fields", {bus.STB, bus.ADDR, bus.WE, bus.DAT_ToTarget}, {1'b1, cur.addr, cur.we, cur.wdat});
    @(negedge clk);
    bus.ACK = 1'b1; bus.DAT_ToInitiator = 8'hAB;
    @(negedge clk);
    bus.ACK = 1'b0;
    chk("rw_datain", DataIn, cur.rdat);
    Read = 1'b0; Write = 1'b0;
    @(negedge clk);

    // Reset while in WAIT
    Ce = 1'b1; Read = 1'b1; Address = 16'h3333;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_wait", {bus.CYC, bus.STB, Delay}, 3'b101);
    rst_n = 1'b0;
    #1 chk("rst_async", {bus.CYC, bus.STB, Delay}, 3'b000);
    @(negedge clk);
    chk("rst_mid_berr", {BusError, DataIn}, {1'b0, 8'hFF});
    Read = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    do_read(16'h1234, 8'h42);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
